// File: rtl/tristate_bus_rx_if.sv
// tristate_bus_rx_if: bus wire, driver enable and receive-side valid/ready port
interface tristate_bus_rx_if #(parameter int DATA_W = 8);
  logic bus_line, bus_drv_en, rd_ready, clr_ovf;
  logic rd_valid, frame_err, overflow, busy;
  logic [DATA_W-1:0] rd_data;
  modport master(output bus_line, bus_drv_en, rd_ready, clr_ovf, input rd_data, rd_valid, frame_err, overflow, busy);
  modport slave(input bus_line, bus_drv_en, rd_ready, clr_ovf, output rd_data, rd_valid, frame_err, overflow, busy);
endinterface

// File: rtl/tristate_bus_rx.sv
// tristate_bus_rx: deserialises MSB-first words off the tristate bus into a show-ahead FIFO
module tristate_bus_rx #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 1
) (
  input logic clk,
  input logic rst,
  tristate_bus_rx_if.slave bus
);
  localparam int BW = $clog2(DATA_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, SHIFT} state_t;
  state_t state, state_n;
  logic [SW-1:0] settle_cnt, settle_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push, pop, valid, full, accept, drop, ferr, ferr_n, ovf;
  always_comb begin
    state_n = state;
    settle_n = settle_cnt;
    bit_n = bit_cnt;
    sh_n = sh;
    push = 1'b0;
    ferr_n = 1'b0;
    unique case (state)
      IDLE: if (bus.bus_drv_en) begin
        state_n = SETTLE_CYC == 1 ? SHIFT : SETTLE;
        settle_n = SW'(1);
      end
      SETTLE: if (!bus.bus_drv_en) state_n = IDLE;
        else if (settle_cnt == SW'(SETTLE_CYC - 1)) state_n = SHIFT;
        else settle_n = settle_cnt + 1'b1;
      SHIFT: if (bus.bus_drv_en) begin
        sh_n = {sh[DATA_W-2:0], bus.bus_line};
        push = bit_cnt == BW'(DATA_W - 1);
        bit_n = push ? '0 : bit_cnt + 1'b1;
      end else begin
        state_n = IDLE;
        ferr_n = bit_cnt != '0;
        bit_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // a full FIFO still takes the new word if the head leaves in the same cycle
  assign valid = cnt != '0;
  assign full = cnt == CW'(FIFO_DEPTH);
  assign pop = valid & bus.rd_ready;
  assign accept = push & (~full | pop);
  assign drop = push & full & ~pop;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      settle_cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      ferr <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      settle_cnt <= settle_n;
      bit_cnt <= bit_n;
      sh <= sh_n;
      ferr <= ferr_n;
      if (accept) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(accept) - CW'(pop);
      ovf <= drop | (ovf & ~bus.clr_ovf);
    end
  end
  always_ff @(posedge clk) if (accept) mem[wp] <= sh_n;
  assign bus.rd_valid = valid;
  assign bus.rd_data = valid ? mem[rp] : '0;
  assign bus.frame_err = ferr;
  assign bus.overflow = ovf;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_tristate_bus_rx.sv
// tb_tristate_bus_rx: directed frames plus random bus traffic checked against a queue-based model
module tb_tristate_bus_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;
  logic clr = 1'b0;
  logic en_r = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [7:0] mq [$];
  int run = 0;
  int nbits = 0;
  logic [7:0] shw = 8'h00;
  logic movf = 1'b0;
  logic mferr = 1'b0;
  logic mbusy = 1'b0;
  logic [7:0] w5 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  tristate_bus_rx_if #(.DATA_W(8)) bus_if();
  tristate_bus_rx #(.DATA_W(8), .FIFO_DEPTH(4), .SETTLE_CYC(1)) dut (.clk(clk), .rst(rst), .bus(bus_if.slave));
  always #5 clk = ~clk;
  // bursts: the first enabled cycle is turnaround, every later one carries a bit
  task automatic mdl(input logic en, input logic line);
    logic pop, push, drop;
    if (rst) begin
      mq.delete();
      run = 0;
      nbits = 0;
      movf = 1'b0;
      mferr = 1'b0;
      mbusy = 1'b0;
    end else begin
      pop = mq.size() > 0 && rdy;
      push = 1'b0;
      mferr = 1'b0;
      if (en) begin
        if (run >= 1) begin
          shw = {shw[6:0], line};
          nbits++;
          if (nbits == 8) begin
            push = 1'b1;
            nbits = 0;
          end
        end
        run++;
      end else begin
        mferr = nbits > 0;
        nbits = 0;
        run = 0;
      end
      if (pop) void'(mq.pop_front());
      drop = push && mq.size() == 4;
      if (push && !drop) mq.push_back(shw);
      movf = drop ? 1'b1 : (clr ? 1'b0 : movf);
      mbusy = en;
    end
  endtask
  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check();
    cmp("rd_valid", {7'b0, bus_if.rd_valid}, {7'b0, mq.size() > 0});
    cmp("rd_data", bus_if.rd_data, mq.size() > 0 ? mq[0] : 8'h00);
    cmp("frame_err", {7'b0, bus_if.frame_err}, {7'b0, mferr});
    cmp("overflow", {7'b0, bus_if.overflow}, {7'b0, movf});
    cmp("busy", {7'b0, bus_if.busy}, {7'b0, mbusy});
  endtask
  task automatic step(input logic en, input logic line);
    bus_if.bus_drv_en = en;
    bus_if.bus_line = line;
    bus_if.rd_ready = rdy;
    bus_if.clr_ovf = clr;
    @(posedge clk);
    mdl(en, line);
    #1;
    check();
  endtask
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i]);
  endtask
  initial begin
    bus_if.bus_drv_en = 1'b0;
    bus_if.bus_line = 1'b0;
    bus_if.rd_ready = 1'b0;
    bus_if.clr_ovf = 1'b0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    cmp("reset_valid", {7'b0, bus_if.rd_valid}, 8'h00);
    cmp("reset_busy", {7'b0, bus_if.busy}, 8'h00);
    rst = 1'b0;
    step(1'b0, 1'b0);
    // single frame, enable rises at cycle 0
    step(1'b1, 1'b0);
    send_word(8'hA5);
    step(1'b0, 1'b0);
    cmp("a5_valid", {7'b0, bus_if.rd_valid}, 8'h01);
    cmp("a5_data", bus_if.rd_data, 8'hA5);
    cmp("a5_busy", {7'b0, bus_if.busy}, 8'h00);
    rdy = 1'b1;
    step(1'b0, 1'b0);
    cmp("a5_popped", {7'b0, bus_if.rd_valid}, 8'h00);
    rdy = 1'b0;
    // back-to-back words in one burst
    step(1'b1, 1'b1);
    send_word(8'h3C);
    send_word(8'hFF);
    send_word(8'h00);
    step(1'b0, 1'b0);
    cmp("b2b_head0", bus_if.rd_data, 8'h3C);
    rdy = 1'b1;
    step(1'b0, 1'b0);
    cmp("b2b_head1", bus_if.rd_data, 8'hFF);
    step(1'b0, 1'b0);
    cmp("b2b_head2", bus_if.rd_data, 8'h00);
    cmp("b2b_valid2", {7'b0, bus_if.rd_valid}, 8'h01);
    step(1'b0, 1'b0);
    cmp("b2b_empty", {7'b0, bus_if.rd_valid}, 8'h00);
    rdy = 1'b0;
    // abort after five data bits
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    cmp("abort_ferr", {7'b0, bus_if.frame_err}, 8'h01);
    cmp("abort_fifo", {7'b0, bus_if.rd_valid}, 8'h00);
    step(1'b0, 1'b0);
    cmp("abort_ferr_off", {7'b0, bus_if.frame_err}, 8'h00);
    step(1'b1, 1'b0);
    send_word(8'h81);
    step(1'b0, 1'b0);
    cmp("after_abort", bus_if.rd_data, 8'h81);
    rdy = 1'b1;
    step(1'b0, 1'b0);
    rdy = 1'b0;
    // five words into a four-deep FIFO
    step(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) send_word(w5[k]);
    step(1'b0, 1'b0);
    cmp("ovf_set", {7'b0, bus_if.overflow}, 8'h01);
    cmp("ovf_head", bus_if.rd_data, 8'h11);
    step(1'b0, 1'b0);
    cmp("ovf_sticky", {7'b0, bus_if.overflow}, 8'h01);
    clr = 1'b1;
    step(1'b0, 1'b0);
    clr = 1'b0;
    cmp("ovf_clr", {7'b0, bus_if.overflow}, 8'h00);
    rdy = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    cmp("ovf_last_kept", bus_if.rd_data, 8'h44);
    step(1'b0, 1'b0);
    cmp("ovf_drained", {7'b0, bus_if.rd_valid}, 8'h00);
    rdy = 1'b0;
    step(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) send_word(w5[k]);
    for (int i = 7; i >= 1; i--) step(1'b1, w5[4][i]);
    rdy = 1'b1;
    step(1'b1, w5[4][0]);
    rdy = 1'b0;
    step(1'b0, 1'b0);
    cmp("full_pop_ovf", {7'b0, bus_if.overflow}, 8'h00);
    cmp("full_pop_head", bus_if.rd_data, 8'h22);
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
    cmp("full_pop_drained", {7'b0, bus_if.rd_valid}, 8'h00);
    rdy = 1'b0;
    // reset in the middle of a frame
    step(1'b1, 1'b0);
    for (int i = 7; i >= 4; i--) step(1'b1, w5[2][i]);
    rst = 1'b1;
    step(1'b1, 1'b1);
    cmp("midrst_busy", {7'b0, bus_if.busy}, 8'h00);
    cmp("midrst_ferr", {7'b0, bus_if.frame_err}, 8'h00);
    rst = 1'b0;
    step(1'b0, 1'b0);
    cmp("midrst_ferr2", {7'b0, bus_if.frame_err}, 8'h00);
    step(1'b1, 1'b1);
    send_word(8'h5A);
    step(1'b0, 1'b0);
    cmp("after_rst", bus_if.rd_data, 8'h5A);
    rdy = 1'b1;
    step(1'b0, 1'b0);
    rdy = 1'b0;
    // settle-only pulse
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    cmp("pulse_busy", {7'b0, bus_if.busy}, 8'h00);
    cmp("pulse_ferr", {7'b0, bus_if.frame_err}, 8'h00);
    cmp("pulse_valid", {7'b0, bus_if.rd_valid}, 8'h00);
    for (int c = 0; c < 3000; c++) begin
      en_r = en_r ? ($urandom_range(99) < 94) : ($urandom_range(99) < 12);
      rdy = $urandom_range(99) < 30;
      clr = $urandom_range(99) < 3;
      rst = $urandom_range(999) < 3;
      step(en_r, 1'($urandom_range(1)));
    end
    rst = 1'b0;
    clr = 1'b0;
    rdy = 1'b1;
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
